instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- Fetches instructions and sits directly upstream of control_block.
- Holds the program counter (PC) and runs a request/acknowledge handshake with instruction memory.
- Latches the returned 32-bit instruction and presents the split fields (opcode, func3, func7, rd, rs1, rs2) with a valid/ready handshake to decode.
- Accepts a PC redirect from execute.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ack  in  1  memory has read data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- dec_ready  in  1  decode accepts the held instruction.
- halt  in  1  stop fetching after the current instruction.
- pc_load  in  1  redirect request.
- pc_load_value  in  XLEN  redirect target; bits [1:0] are forced to 0.
- instr_valid  out  1  fields below are valid.
- pc_out  out  XLEN  address of the held instruction.
- opcode  out  7  ir[6:0].
- rd  out  5  ir[11:7].
- func3  out  3  ir[14:12].
- rs1  out  5  ir[19:15].
- rs2  out  5  ir[24:20].
- func7  out  7  ir[31:25].

Behaviour:
- Reset (async assert, takes effect immediately):
  - pc=RESET_PC, state=IDLE, ir=0, pc_out=0, instr_valid=0, imem_req=0, kill=0.
  - All field outputs are 0.
- States: IDLE, FETCH, VALID. Encoding is 2-bit.
- IDLE:
  - imem_req=0.
  - Next cycle goes to FETCH unless halt=1.
  - pc_load=1 sets pc<=target and goes to FETCH unless halt.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On imem_ack with kill=0 and pc_load=0: ir<=imem_rdata, pc_out<=pc, pc<=pc+PC_STEP, go to VALID.
  - Latency: instr_valid rises the cycle after ack.
- VALID:
  - instr_valid=1, and ir and pc_out are held stable while dec_ready=0.
  - On dec_ready=1: go to IDLE if halt=1, else FETCH. instr_valid falls the next cycle.
- Redirect, pc_load=1 (highest priority):
  - In FETCH with no ack this cycle: set kill<=1 and tgt<=target. The request stays outstanding at the old address.
  - When that ack arrives, imem_rdata is discarded: pc<=tgt, kill<=0, stay in FETCH, and imem_addr changes the next cycle.
  - In FETCH with ack in the same cycle: discard the data, pc<=target, stay in FETCH.
  - Second redirect while kill=1: tgt is overwritten, so the last target wins.
  - In VALID: the held instruction is dropped (instr_valid=0 next cycle, whatever dec_ready is), pc<=target, go to FETCH.
- Arithmetic: pc+PC_STEP wraps modulo 2^XLEN. 0xFFFF_FFFC+4 gives 0x0000_0000.
- halt=1 in FETCH has no effect until VALID is consumed.
- Reset mid-fetch drops the request immediately. Any later imem_ack is ignored, because the block is in IDLE.
- Field outputs are combinational slices of ir and stay valid only while instr_valid=1. ir is not cleared on consume.

Decomposition:
- riscv_pkg holds:
  - opcode constants (OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_LOAD, OP_STORE, OP_BRANCH).
  - field bit positions.
  - fetch state encoding (ST_IDLE=2'd0, ST_FETCH=2'd1, ST_VALID=2'd2).
  - PC_STEP default.
- Sub-module instr_field_split: purely combinational, 32-bit ir in, six field outputs. It is reused by control_block test benches.

Test Plan:
- Reset, release, imem_ack after 2 cycles with rdata=32'h40B50533 (sub x10,x10,x11), dec_ready=1 -> imem_addr=0x0. instr_valid rises 1 cycle after ack with opcode=0110011, func3=000, func7=0100000, rd=10, rs1=10, rs2=11, pc_out=0. Next imem_addr=0x4.
- dec_ready=0 for 5 cycles in VALID -> instr_valid and fields are stable. No imem_req is raised. Release gives one consume, then FETCH at 0x8.
- pc_load=1, value=0x103, 1 cycle before a pending ack -> the acked data is never presented (instr_valid stays 0). Next imem_addr=0x100.
- pc_load the same cycle as imem_ack with target 0x200 -> data is dropped and the next request is at 0x200. pc_load in VALID gives instr_valid=0 next cycle.
- Start with pc=0xFFFF_FFFC (redirect) and fetch one instruction -> pc_out=0xFFFF_FFFC and the next imem_addr=0x0.
- Assert reset asynchronously while imem_req=1 -> imem_req and instr_valid are 0 before the next clock edge. A late ack is ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: opcodes, instruction field positions, fetch FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    // Base opcodes seen by fetch/decode
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Instruction field LSB positions and widths
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int RD_LSB     = 7;
    localparam int RD_W       = 5;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC3_W    = 3;
    localparam int RS1_LSB    = 15;
    localparam int RS1_W      = 5;
    localparam int RS2_LSB    = 20;
    localparam int RS2_W      = 5;
    localparam int FUNC7_LSB  = 25;
    localparam int FUNC7_W    = 7;

    // Sequential fetch increment
    localparam int PC_STEP_DEFAULT = 4;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_field_split.sv
// Splits a 32-bit RV32 instruction word into its fixed-position fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: i_ir (instruction word) -> o_opcode, o_rd, o_func3, o_rs1, o_rs2, o_func7.
module instr_field_split
    import riscv_pkg::*;
(
    input  logic [31:0]          i_ir,
    output logic [OPCODE_W-1:0]  o_opcode,
    output logic [RD_W-1:0]      o_rd,
    output logic [FUNC3_W-1:0]   o_func3,
    output logic [RS1_W-1:0]     o_rs1,
    output logic [RS2_W-1:0]     o_rs2,
    output logic [FUNC7_W-1:0]   o_func7
);

    assign o_opcode = i_ir[OPCODE_LSB +: OPCODE_W];
    assign o_rd     = i_ir[RD_LSB     +: RD_W];
    assign o_func3  = i_ir[FUNC3_LSB  +: FUNC3_W];
    assign o_rs1    = i_ir[RS1_LSB    +: RS1_W];
    assign o_rs2    = i_ir[RS2_LSB    +: RS2_W];
    assign o_func7  = i_ir[FUNC7_LSB  +: FUNC7_W];

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, handshakes with instruction memory, holds one instruction for decode.
// Latency: instr_valid rises one cycle after imem_ack; next request issues the cycle after decode consumes.
// Backpressure: holds ir/pc_out stable and raises no new request while dec_ready=0; redirect drops the held word.
// Ports: clk/reset; imem_req/imem_addr/imem_ack/imem_rdata (memory side);
//        dec_ready/halt/pc_load/pc_load_value (control in); instr_valid/pc_out/opcode/rd/func3/rs1/rs2/func7 (to decode).
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              dec_ready,
    input  logic              halt,
    input  logic              pc_load,
    input  logic [XLEN-1:0]   pc_load_value,
    output logic              instr_valid,
    output logic [XLEN-1:0]   pc_out,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        func3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        func7
);

    fetch_state_t       r_state;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_tgt;
    logic               r_kill;
    logic [31:0]        r_ir;
    logic [XLEN-1:0]    r_pc_out;
    logic               r_imem_req;
    logic               r_instr_valid;

    logic [XLEN-1:0]    w_target;
    logic [XLEN-1:0]    w_pc_next;

    // Redirect targets are always word aligned
    assign w_target  = {pc_load_value[XLEN-1:2], 2'b00};
    // Wraps naturally modulo 2^XLEN
    assign w_pc_next = r_pc + XLEN'(PC_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_tgt         <= '0;
            r_kill        <= 1'b0;
            r_ir          <= '0;
            r_pc_out      <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pc_load) begin
                        r_pc <= w_target;
                    end
                    if (!halt) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (imem_ack) begin
                        if (pc_load) begin
                            // Redirect coincides with the data: drop it, refetch at the target
                            r_pc   <= w_target;
                            r_kill <= 1'b0;
                        end else if (r_kill) begin
                            // Ack for a request overtaken by an earlier redirect
                            r_pc   <= r_tgt;
                            r_kill <= 1'b0;
                        end else begin
                            r_ir          <= imem_rdata;
                            r_pc_out      <= r_pc;
                            r_pc          <= w_pc_next;
                            r_state       <= ST_VALID;
                            r_imem_req    <= 1'b0;
                            r_instr_valid <= 1'b1;
                        end
                    end else if (pc_load) begin
                        // Memory still owes us the old word; remember where to go once it lands.
                        // A later redirect before the ack overwrites the target.
                        r_kill <= 1'b1;
                        r_tgt  <= w_target;
                    end
                end

                ST_VALID: begin
                    if (pc_load) begin
                        r_pc          <= w_target;
                        r_state       <= ST_FETCH;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end else if (dec_ready) begin
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_imem_req <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_kill        <= 1'b0;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign pc_out      = r_pc_out;

    instr_field_split u_field_split (
        .i_ir     (r_ir),
        .o_opcode (opcode),
        .o_rd     (rd),
        .o_func3  (func3),
        .o_rs1    (rs1),
        .o_rs2    (rs2),
        .o_func7  (func7)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a scoreboard of expected presented instructions.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_ready;
    logic        halt;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .dec_ready     (dec_ready),
        .halt          (halt),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .opcode        (opcode),
        .rd            (rd),
        .func3         (func3),
        .rs1           (rs1),
        .rs2           (rs2),
        .func7         (func7)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pop the next expected instruction and compare the presented fields
    task automatic check_present(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"},  32'(instr_valid), 32'd1);
            check({tag, "_pc_out"}, pc_out,           e.pc);
            check({tag, "_opcode"}, 32'(opcode),      32'(e.ir[6:0]));
            check({tag, "_rd"},     32'(rd),          32'(e.ir[11:7]));
            check({tag, "_func3"},  32'(func3),       32'(e.ir[14:12]));
            check({tag, "_rs1"},    32'(rs1),         32'(e.ir[19:15]));
            check({tag, "_rs2"},    32'(rs2),         32'(e.ir[24:20]));
            check({tag, "_func7"},  32'(func7),       32'(e.ir[31:25]));
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ir);
        exp_t e;
        e.pc = pc;
        e.ir = ir;
        sb.push_back(e);
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        dec_ready     = 1'b0;
        halt          = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 32'h0;

        // Reset state
        @(negedge clk);
        check("rst_req",    32'(imem_req),    32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_addr",   imem_addr,        32'h0);
        check("rst_pc_out", pc_out,           32'h0);
        check("rst_opcode", 32'(opcode),      32'd0);
        check("rst_rd",     32'(rd),          32'd0);
        check("rst_func7",  32'(func7),       32'd0);
        reset = 1'b0;

        // First fetch: IDLE -> FETCH at 0, ack two cycles later
        tick();
        check("f1_req",  32'(imem_req), 32'd1);
        check("f1_addr", imem_addr,     32'h0);
        tick();
        check("f1_hold_req",  32'(imem_req), 32'd1);
        check("f1_hold_addr", imem_addr,     32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h40B5_0533;
        dec_ready  = 1'b1;
        push(32'h0, 32'h40B5_0533);
        tick();
        imem_ack = 1'b0;
        check("f1_opcode_lit", 32'(opcode), 32'(OP_RTYPE));
        check("f1_func7_lit",  32'(func7),  32'h20);
        check("f1_rs2_lit",    32'(rs2),    32'd11);
        check_present("f1");
        tick();
        check("f1_next_valid", 32'(instr_valid), 32'd0);
        check("f1_next_req",   32'(imem_req),    32'd1);
        check("f1_next_addr",  imem_addr,        32'h4);

        // Decode stall for five cycles
        dec_ready  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A5_8593;
        push(32'h4, 32'h00A5_8593);
        tick();
        imem_ack = 1'b0;
        check("stall_opcode_lit", 32'(opcode), 32'(OP_ITYPE));
        check_present("stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid",  32'(instr_valid), 32'd1);
            check("stall_no_req", 32'(imem_req),    32'd0);
            check("stall_pc_out", pc_out,           32'h4);
            check("stall_rd",     32'(rd),          32'd11);
            check("stall_imm",    32'({func7, rs2}), 32'd10);
        end
        dec_ready = 1'b1;
        tick();
        check("stall_rel_valid", 32'(instr_valid), 32'd0);
        check("stall_rel_req",   32'(imem_req),    32'd1);
        check("stall_rel_addr",  imem_addr,        32'h8);

        // Redirect one cycle ahead of the ack: the acked word must be discarded
        pc_load       = 1'b1;
        pc_load_value = 32'h0000_0103;
        tick();
        pc_load = 1'b0;
        check("kill_addr_held", imem_addr,        32'h8);
        check("kill_req_held",  32'(imem_req),    32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("kill_valid",  32'(instr_valid), 32'd0);
        check("kill_addr",   imem_addr,        32'h100);
        tick();
        check("kill_valid2", 32'(instr_valid), 32'd0);
        check("kill_addr2",  imem_addr,        32'h100);

        // Redirect in the same cycle as the ack
        imem_ack      = 1'b1;
        imem_rdata    = 32'h1234_5678;
        pc_load       = 1'b1;
        pc_load_value = 32'h0000_0200;
        tick();
        imem_ack = 1'b0;
        pc_load  = 1'b0;
        check("same_valid", 32'(instr_valid), 32'd0);
        check("same_req",   32'(imem_req),    32'd1);
        check("same_addr",  imem_addr,        32'h200);

        // Fetch at 0x200, then redirect while it is held in VALID
        dec_ready  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0062_A023;
        push(32'h200, 32'h0062_A023);
        tick();
        imem_ack = 1'b0;
        check("st_opcode_lit", 32'(opcode), 32'(OP_STORE));
        check_present("st");
        pc_load       = 1'b1;
        pc_load_value = 32'hFFFF_FFFE;
        dec_ready     = 1'b1;
        tick();
        pc_load = 1'b0;
        check("vredir_valid", 32'(instr_valid), 32'd0);
        check("vredir_req",   32'(imem_req),    32'd1);
        check("vredir_addr",  imem_addr,        32'hFFFF_FFFC);

        // Fetch at the top of the address space, PC wraps to 0
        dec_ready  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFE00_08E3;
        push(32'hFFFF_FFFC, 32'hFE00_08E3);
        tick();
        imem_ack = 1'b0;
        check("wrap_opcode_lit", 32'(opcode), 32'(OP_BRANCH));
        check_present("wrap");
        dec_ready = 1'b1;
        tick();
        check("wrap_addr", imem_addr,     32'h0);
        check("wrap_req",  32'(imem_req), 32'd1);

        // halt during FETCH only takes effect after the held word is consumed
        halt       = 1'b1;
        dec_ready  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_A103;
        push(32'h0, 32'h0000_A103);
        tick();
        imem_ack = 1'b0;
        check("halt_opcode_lit", 32'(opcode), 32'(OP_LOAD));
        check_present("halt");
        dec_ready = 1'b1;
        tick();
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_req",   32'(imem_req),    32'd0);
        tick();
        check("halt_req2",  32'(imem_req),    32'd0);
        halt = 1'b0;
        tick();
        check("unhalt_req",  32'(imem_req), 32'd1);
        check("unhalt_addr", imem_addr,     32'h4);

        // Asynchronous reset mid-fetch, then a late ack
        #2;
        reset = 1'b1;
        #1;
        check("arst_req",   32'(imem_req),    32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_addr",  imem_addr,        32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        reset = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("late_ack_req",   32'(imem_req),    32'd1);
        check("late_ack_addr",  imem_addr,        32'h0);

        // Normal fetch after reset recovery
        dec_ready  = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00B5_0533;
        push(32'h0, 32'h00B5_0533);
        tick();
        imem_ack = 1'b0;
        check_present("post_rst");
        tick();
        check("post_rst_addr", imem_addr, 32'h4);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
